regfile_dump: RTL and testbench

- Sequential reader for the 32x32 MIPS register file. It walks the register file read port from register 0 up to register NUM_REGS-1.
- Each register word is streamed out on a valid/ready interface, for trace capture and end-of-test state comparison.
- It drives one register-file read address and consumes the matching combinational read data. It has no write capability.
- Sits beside the register file in the datapath and is controlled from the testbench/debug controller.

---
 rtl/regfile_dump_if.sv | 39 +++
 rtl/regfile_dump.sv | 117 +++++++++++
 tb/tb_regfile_dump.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// regfile_dump_if: output beat stream of the register file dumper.
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data, out_index and
// out_last hold steady until that transfer. out_valid never waits on
// out_ready. out_ready may stay low for any number of cycles.
//
// Signals:
//   out_valid  master->slave  beat present
//   out_ready  slave->master  beat accepted when high with out_valid
//   out_data   master->slave  register contents
//   out_index  master->slave  register number of out_data
//   out_last   master->slave  final beat of the dump
interface regfile_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump: walks the register file read port from register 0 up to
// NUM_REGS-1 and streams each word out as one beat.
//
// Optional feature macro: REGFILE_DUMP_CHECKSUM_EN adds a checksum output
// holding the running XOR of every accepted beat.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle dump request; only looked at in IDLE
//   busy       high in READ and SEND
//   done       one-cycle pulse after the final beat is accepted
//   rd_addr    register file read address
//   rd_data    combinational register file read data for rd_addr
//   out        beat stream (regfile_dump_if master)
//   checksum   running XOR of accepted beats (macro builds only)
//   dbg_state  current FSM state: 0 IDLE, 1 READ, 2 SEND, 3 DONE
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  regfile_dump_if.master    out,
`ifdef REGFILE_DUMP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;

  assign dbg_state = state;

  // rd_addr is registered: it is loaded with the index of the coming READ
  // on the edge that enters READ, so it is valid throughout that cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_addr       <= '0;
      out.out_valid <= 1'b0;
      out.out_data  <= '0;
      out.out_index <= '0;
      out.out_last  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      checksum      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rd_addr <= '0;
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        READ: begin
          out.out_data  <= rd_data;
          out.out_index <= idx;
          out.out_last  <= (idx == LAST_IDX);
          out.out_valid <= 1'b1;
          state         <= SEND;
        end
        SEND: begin
          if (out.out_valid && out.out_ready) begin
            out.out_valid <= 1'b0;
            out.out_last  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            checksum <= checksum ^ out.out_data;
`endif
            if (idx == LAST_IDX) begin
              // The index stops here; there is no beat past the last register.
              busy    <= 1'b0;
              done    <= 1'b1;
              rd_addr <= '0;
              state   <= DONE;
            end else begin
              idx     <= idx + 1'b1;
              rd_addr <= idx + 1'b1;
              state   <= READ;
            end
          end
        end
        DONE: begin
          // start is not looked at here, so a request in this cycle is lost.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  dbg_state;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) sif ();

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out       (sif.master),
`ifdef REGFILE_DUMP_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file model ----------------
  logic [31:0] rf [32];
  assign rd_data = (rd_addr == 5'd0) ? 32'd0 : rf[rd_addr];

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_reg(input int i, input logic [31:0] v);
    if (i != 0) rf[i] = v;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_done"},   32'(done), 32'd0);
    check({tag, "_valid"},  32'(sif.out_valid), 32'd0);
    check({tag, "_last"},   32'(sif.out_last), 32'd0);
    check({tag, "_data"},   sif.out_data, 32'd0);
    check({tag, "_index"},  32'(sif.out_index), 32'd0);
    check({tag, "_rdaddr"}, 32'(rd_addr), 32'd0);
    check({tag, "_state"},  32'(dbg_state), 32'd0);
  endtask

  // Runs one dump from a start pulse, checking every beat against exp_q.
  // Negative beat numbers disable the corresponding option.
  task automatic run_dump(input int stall_beat, input int stall_len,
                          input int restart_beat, input int wr_beat,
                          input int wr_idx, input logic [31:0] wr_val,
                          input int abort_beat, input int exp_done_cyc,
                          input bit start_on_done);
    int beat, cyc, stalled, dones;
    bit fin, wrote, restarted;
    logic [31:0] exp_d;
    beat = 0; cyc = 0; stalled = 0; dones = 0;
    fin = 0; wrote = 0; restarted = 0;
    sif.out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    check("first_read_busy",  32'(busy), 32'd1);
    check("first_read_state", 32'(dbg_state), 32'd1);
    check("first_read_valid", 32'(sif.out_valid), 32'd0);
    while (!fin && cyc < 400) begin
      if (start) start = 1'b0;
      if (sif.out_valid && beat == abort_beat) begin
        reset = 1'b0;
        #1;
        check_reset_state("abort");
        @(negedge clk); reset = 1'b1;
        return;
      end
      if (sif.out_valid) begin
        if (beat == wr_beat && !wrote) begin
          write_reg(wr_idx, wr_val);
          wrote = 1;
        end
        if (beat == restart_beat && !restarted) begin
          start = 1'b1;
          restarted = 1;
        end
        if (beat == stall_beat && stalled < stall_len) begin
          sif.out_ready = 1'b0;
          stalled++;
          check("stall_valid", 32'(sif.out_valid), 32'd1);
          check("stall_data",  sif.out_data, (exp_q.size() > 0) ? exp_q[0] : 32'hxxxxxxxx);
          check("stall_index", 32'(sif.out_index), 32'(beat));
        end else begin
          sif.out_ready = 1'b1;
          exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
          check("beat_data",  sif.out_data, exp_d);
          check("beat_index", 32'(sif.out_index), 32'(beat));
          check("beat_last",  32'(sif.out_last), 32'(beat == 31));
          check("beat_busy",  32'(busy), 32'd1);
          beat++;
        end
      end
      if (done) begin
        dones++;
        fin = 1;
        if (exp_done_cyc > 0) check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
        check("done_busy", 32'(busy), 32'd0);
        if (start_on_done) start = 1'b1;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("dump_finished", 32'(fin), 32'd1);
    check("beat_count", 32'(beat), 32'd32);
    check("done_count", 32'(dones), 32'd1);
    @(negedge clk); start = 1'b0;
    check("done_pulse_width", 32'(done), 32'd0);
    check("idle_after_done", 32'(dbg_state), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("still_idle", 32'(dbg_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    start = 1'b0;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("idle");

    // rf[i] = i*3, full dump with ready high; start lands in DONE and is lost.
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      write_reg(i, 32'(i * 3));
      exp_q.push_back(32'(i * 3));
    end
    run_dump(-1, 0, -1, -1, 0, 32'd0, -1, 65, 1'b1);

    // Five cycles of backpressure on beat 7, start pulse again at beat 10.
    exp_q.delete();
    write_reg(7, 32'hDEADBEEF);
    for (int i = 0; i < 32; i++) exp_q.push_back((i == 7) ? 32'hDEADBEEF : 32'(i * 3));
    run_dump(7, 5, 10, -1, 0, 32'd0, -1, 70, 1'b0);

    // rf[0] write attempt, then rf[20] written while beat 5 is on the bus.
    exp_q.delete();
    write_reg(0, 32'hFFFFFFFF);
    for (int i = 0; i < 32; i++)
      exp_q.push_back((i == 7) ? 32'hDEADBEEF : (i == 20) ? 32'h12345678 : 32'(i * 3));
    run_dump(-1, 0, -1, 5, 20, 32'h12345678, -1, 65, 1'b0);

    // Reset asserted while beat 12 waits; the next dump starts at register 0.
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i * 3));
    for (int i = 0; i < 32; i++) write_reg(i, 32'(i * 3));
    run_dump(-1, 0, -1, -1, 0, 32'd0, 12, 0, 1'b0);
    @(negedge clk);
    check_reset_state("post_abort");

    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i * 3));
    run_dump(-1, 0, -1, -1, 0, 32'd0, -1, 65, 1'b0);

    // rf[i] = i: XOR of 0..31 is 0.
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      write_reg(i, 32'(i));
      exp_q.push_back(32'(i));
    end
    run_dump(-1, 0, -1, -1, 0, 32'd0, -1, 65, 1'b0);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    check("checksum_ramp", checksum, 32'd0);
`endif

    // rf[i] = 1<<i with register 0 reading 0: XOR is 32'hFFFFFFFE.
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      write_reg(i, 32'd1 << i);
      exp_q.push_back((i == 0) ? 32'd0 : (32'd1 << i));
    end
    run_dump(-1, 0, -1, -1, 0, 32'd0, -1, 65, 1'b0);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    check("checksum_onehot", checksum, 32'hFFFFFFFE);
    repeat (3) @(negedge clk);
    check("checksum_hold", checksum, 32'hFFFFFFFE);
`endif

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
